button_debouncer: RTL and testbench

//  Cleans a raw, asynchronous, bouncing input (push button, switch) into a stable

---
 rtl/button_debouncer_if.sv | 40 ++++
 rtl/button_debouncer.sv | 155 +++++++++++++++
 tb/tb_button_debouncer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer_if
// Purpose  : Groups the data-side signals of the button debouncer.
//            The master drives the raw input and the count-clear strobe;
//            the slave (the debouncer) returns the cleaned level, the
//            qualification-in-progress flag and the bounce counter.
// Signals  : i_in            raw asynchronous input (may bounce)
//            i_clear_count   synchronous clear of o_bounce_count
//            o_out           debounced, registered level
//            o_busy          1 while a candidate transition is qualified
//            o_bounce_count  saturating count of aborted transitions
// Revision : 1.0 - initial release
// ============================================================================
interface button_debouncer_if #(
   parameter int COUNT_W = 8
);
   logic               i_in;
   logic               i_clear_count;
   logic               o_out;
   logic               o_busy;
   logic [COUNT_W-1:0] o_bounce_count;

   modport master (
      output i_in,
      output i_clear_count,
      input  o_out,
      input  o_busy,
      input  o_bounce_count
   );

   modport slave (
      input  i_in,
      input  i_clear_count,
      output o_out,
      output o_busy,
      output o_bounce_count
   );
endinterface
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Purpose  : Synchronises a raw bouncing input into clk and only accepts a
//            level change after it has been stable for BOUNCE_CYCLES
//            consecutive cycles. Aborted candidate transitions are counted
//            in a saturating counter for board bring-up.
// Ports    : clk   system clock, all state on posedge
//            rst   asynchronous active-low reset (0 = reset)
//            bus   button_debouncer_if.slave (i_in, i_clear_count,
//                  o_out, o_busy, o_bounce_count)
// Revision : 1.0 - initial release
// ============================================================================
module button_debouncer #(
   parameter int SYNC_STAGES   = 2,
   parameter int BOUNCE_CYCLES = 8,
   parameter int COUNT_W       = 8
) (
   input  wire logic           clk,
   input  wire logic           rst,
   button_debouncer_if.slave   bus
);

   localparam int                 CNT_W       = $clog2(BOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]   c_CNT_LAST  = CNT_W'(BOUNCE_CYCLES - 1);
   localparam logic [COUNT_W-1:0] c_COUNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_STABLE_LOW   = 2'd0,
      ST_PENDING_HIGH = 2'd1,
      ST_STABLE_HIGH  = 2'd2,
      ST_PENDING_LOW  = 2'd3
   } state_t;

   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("button_debouncer: SYNC_STAGES must be >= 2");
      end
      if (BOUNCE_CYCLES < 1) begin : g_bad_bounce
         $error("button_debouncer: BOUNCE_CYCLES must be >= 1");
      end
   endgenerate

   logic [SYNC_STAGES-1:0] r_sync;
   state_t                 r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_out;
   logic                   r_busy;
   logic [COUNT_W-1:0]     r_bounce_count;

   logic                   w_sync;
   state_t                 w_state_nxt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   w_out_nxt;
   logic                   w_busy_nxt;
   logic                   w_abort;
   logic [COUNT_W-1:0]     w_count_nxt;

   // Only the last synchroniser stage is ever looked at by the FSM.
   assign w_sync = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_in};
      end
   end

   // Next-state logic. A reversal while pending returns to the stable state
   // we came from, so qualification always restarts from scratch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_out_nxt   = r_out;
      w_abort     = 1'b0;
      case (r_state)
         ST_STABLE_LOW: begin
            w_out_nxt = 1'b0;
            if (w_sync) begin
               w_state_nxt = ST_PENDING_HIGH;
               w_cnt_nxt   = '0;
            end
         end
         ST_PENDING_HIGH: begin
            if (!w_sync) begin
               w_state_nxt = ST_STABLE_LOW;
               w_abort     = 1'b1;
            end else if (r_cnt == c_CNT_LAST) begin
               w_state_nxt = ST_STABLE_HIGH;
               w_out_nxt   = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         ST_STABLE_HIGH: begin
            w_out_nxt = 1'b1;
            if (!w_sync) begin
               w_state_nxt = ST_PENDING_LOW;
               w_cnt_nxt   = '0;
            end
         end
         ST_PENDING_LOW: begin
            if (w_sync) begin
               w_state_nxt = ST_STABLE_HIGH;
               w_abort     = 1'b1;
            end else if (r_cnt == c_CNT_LAST) begin
               w_state_nxt = ST_STABLE_LOW;
               w_out_nxt   = 1'b0;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_STABLE_LOW;
            w_cnt_nxt   = '0;
            w_out_nxt   = 1'b0;
         end
      endcase

      // busy is registered from the next state so it tracks PENDING_* exactly
      w_busy_nxt = (w_state_nxt == ST_PENDING_HIGH) ||
                   (w_state_nxt == ST_PENDING_LOW);

      // Clear wins over a simultaneous abort; the counter never wraps.
      w_count_nxt = r_bounce_count;
      if (bus.i_clear_count) begin
         w_count_nxt = '0;
      end else if (w_abort && (r_bounce_count != c_COUNT_MAX)) begin
         w_count_nxt = r_bounce_count + COUNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= ST_STABLE_LOW;
         r_cnt          <= '0;
         r_out          <= 1'b0;
         r_busy         <= 1'b0;
         r_bounce_count <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_cnt          <= w_cnt_nxt;
         r_out          <= w_out_nxt;
         r_busy         <= w_busy_nxt;
         r_bounce_count <= w_count_nxt;
      end
   end

   assign bus.o_out          = r_out;
   assign bus.o_busy         = r_busy;
   assign bus.o_bounce_count = r_bounce_count;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debouncer
// Purpose  : Self-checking bench for button_debouncer. Stimulus pushes the
//            expected edge (cycle, level) of o_out into a scoreboard queue;
//            a monitor pops and compares whenever o_out changes. Counter and
//            busy values are checked directly against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

   logic clk;
   logic rst;
   int   cyc;
   int   total;
   int   bad;
   int   busy_cnt;
   logic prev_out;

   typedef struct {
      int   cyc;
      logic val;
   } ev_t;

   ev_t sbq[$];

   button_debouncer_if #(.COUNT_W(8)) bus  ();
   button_debouncer_if #(.COUNT_W(2)) bus2 ();

   button_debouncer #(
      .SYNC_STAGES   (2),
      .BOUNCE_CYCLES (8),
      .COUNT_W       (8)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   button_debouncer #(
      .SYNC_STAGES   (2),
      .BOUNCE_CYCLES (8),
      .COUNT_W       (2)
   ) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cyc=%0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Expected o_out edge: first sampling edge is cyc+1, output moves 10 edges later.
   task automatic expect_edge(input logic v);
      ev_t e;
      e.cyc = cyc + 11;
      e.val = v;
      sbq.push_back(e);
   endtask

   // Monitor: compares every change of o_out against the scoreboard.
   initial prev_out = 1'b0;
   always @(negedge clk) begin
      if (bus.o_busy) busy_cnt++;
      if (rst && (bus.o_out !== prev_out)) begin
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL out_edge_unexpected: got val=%0b at cyc=%0d expected no change",
                     bus.o_out, cyc);
         end else begin
            ev_t e;
            e = sbq.pop_front();
            if ((e.cyc != cyc) || (e.val !== bus.o_out)) begin
               bad++;
               $display("FAIL out_edge: got cyc=%0d val=%0b expected cyc=%0d val=%0b",
                        cyc, bus.o_out, e.cyc, e.val);
            end
         end
      end
      prev_out = bus.o_out;
   end

   initial begin
      total    = 0;
      bad      = 0;
      busy_cnt = 0;
      rst               = 1'b0;
      bus.i_in          = 1'b0;
      bus.i_clear_count = 1'b0;
      bus2.i_in         = 1'b0;
      bus2.i_clear_count = 1'b0;

      // Reset state
      tick(2);
      chk("reset_out",   int'(bus.o_out), 0);
      chk("reset_busy",  int'(bus.o_busy), 0);
      chk("reset_count", int'(bus.o_bounce_count), 0);
      #2 rst = 1'b1;
      tick(3);

      // Clean rise
      bus.i_in = 1'b1;
      expect_edge(1'b1);
      busy_cnt = 0;
      tick(12);
      chk("rise_busy_cycles", busy_cnt, 8);
      chk("rise_out", int'(bus.o_out), 1);
      chk("rise_count", int'(bus.o_bounce_count), 0);

      // Clean fall
      bus.i_in = 1'b0;
      expect_edge(1'b0);
      busy_cnt = 0;
      tick(12);
      chk("fall_busy_cycles", busy_cnt, 8);
      chk("fall_out", int'(bus.o_out), 0);

      // Bounce: 3 high, 3 low, 3 high, 3 low, then held high
      bus.i_in = 1'b1; tick(3);
      bus.i_in = 1'b0; tick(3);
      bus.i_in = 1'b1; tick(3);
      bus.i_in = 1'b0; tick(3);
      bus.i_in = 1'b1;
      expect_edge(1'b1);
      tick(12);
      chk("bounce_count", int'(bus.o_bounce_count), 2);
      chk("bounce_out", int'(bus.o_out), 1);

      // Low glitch from STABLE_HIGH
      bus.i_in = 1'b0; tick(1);
      bus.i_in = 1'b1; tick(12);
      chk("glitch_low_out", int'(bus.o_out), 1);
      chk("glitch_low_count", int'(bus.o_bounce_count), 3);

      // Fall, then high glitch from STABLE_LOW
      bus.i_in = 1'b0;
      expect_edge(1'b0);
      tick(12);
      bus.i_in = 1'b1; tick(1);
      bus.i_in = 1'b0; tick(12);
      chk("glitch_high_out", int'(bus.o_out), 0);
      chk("glitch_high_count", int'(bus.o_bounce_count), 4);

      // Async reset while qualifying, with in held high afterwards
      bus.i_in = 1'b1;
      tick(5);
      chk("pre_reset_busy", int'(bus.o_busy), 1);
      #2 rst = 1'b0;
      #1;
      chk("async_out",   int'(bus.o_out), 0);
      chk("async_busy",  int'(bus.o_busy), 0);
      chk("async_count", int'(bus.o_bounce_count), 0);
      #2 rst = 1'b1;
      expect_edge(1'b1);
      tick(12);
      chk("post_reset_out", int'(bus.o_out), 1);
      chk("post_reset_count", int'(bus.o_bounce_count), 0);

      // Saturation on the 2-bit counter instance
      for (int g = 0; g < 5; g++) begin
         bus2.i_in = 1'b1; tick(1);
         bus2.i_in = 1'b0; tick(4);
      end
      chk("sat_count", int'(bus2.o_bounce_count), 3);
      chk("sat_out", int'(bus2.o_out), 0);

      // Sixth abort lands on the same edge as clear_count
      bus2.i_in = 1'b1; tick(1);
      bus2.i_in = 1'b0; tick(2);
      chk("clr_pending_busy", int'(bus2.o_busy), 1);
      bus2.i_clear_count = 1'b1; tick(1);
      bus2.i_clear_count = 1'b0;
      chk("clr_abort_count", int'(bus2.o_bounce_count), 0);
      chk("clr_abort_busy", int'(bus2.o_busy), 0);
      tick(4);
      chk("clr_hold_count", int'(bus2.o_bounce_count), 0);

      chk("sb_drain", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
